rr_arb_mux: RTL and testbench

Round-robin N:1 arbitrated multiplexer with valid/ready handshakes and a one-entry registered output stage. It sits directly downstream of per-port requesters, or wherever several producers share one consumer channel. It carries the winning data and source index to a single registered output. Fairness is round-robin: priority starts at the port after the last accepted one.

---
 rtl/rr_arb_pkg.sv | 47 ++++
 rtl/rr_out_slice.sv | 36 +++
 rtl/rr_arb_mux.sv | 94 +++++++++
 tb/tb_rr_arb_mux.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rr_arb_pkg.sv
// Shared helpers for the round-robin arbitrated mux: wrap increment and
// rotating-priority winner search, sized for up to RR_MAX_PORT requesters.
package rr_arb_pkg;

    localparam int RR_MAX_PORT = 64;
    localparam int RR_MAX_IDX  = 6;

    typedef struct packed {
        logic                  found;
        logic [RR_MAX_IDX-1:0] idx;
    } rr_pick_t;

    // Wraps at nport-1 -> 0, so non-power-of-two port counts never step
    // into an unused index.
    function automatic logic [RR_MAX_IDX-1:0] rr_next(
        input logic [RR_MAX_IDX-1:0] idx,
        input int unsigned           nport
    );
        logic [RR_MAX_IDX-1:0] nxt;
        if (32'(idx) == nport - 1)
            nxt = '0;
        else
            nxt = idx + RR_MAX_IDX'(1);
        return nxt;
    endfunction

    function automatic rr_pick_t rr_pick(
        input logic [RR_MAX_PORT-1:0] req,
        input logic [RR_MAX_IDX-1:0]  ptr,
        input int unsigned            nport
    );
        rr_pick_t    r;
        int unsigned i;
        r = '0;
        for (int unsigned k = 0; k < RR_MAX_PORT; k++) begin
            i = 32'(ptr) + k;
            if (i >= nport)
                i = i - nport;
            if (k < nport && !r.found && req[i[RR_MAX_IDX-1:0]]) begin
                r.found = 1'b1;
                r.idx   = i[RR_MAX_IDX-1:0];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_out_slice.sv
// One-entry registered output stage with valid/ready; loads when empty or
// draining in the same cycle. Carries an opaque W-bit word.
module rr_out_slice #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load_i,
    input  logic [W-1:0] data_i,
    input  logic         ready_i,
    output logic         can_load_o,
    output logic         valid_o,
    output logic [W-1:0] data_o
);

    logic         valid_q;
    logic [W-1:0] data_q;

    assign can_load_o = !valid_q || ready_i;
    assign valid_o    = valid_q;
    assign data_o     = data_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (load_i) begin
            valid_q <= 1'b1;
            data_q  <= data_i;
        end else if (ready_i) begin
            // Drain without refill: payload is kept, only valid drops.
            valid_q <= 1'b0;
        end
    end

endmodule

// File: rtl/rr_arb_mux.sv
// Round-robin N:1 arbitrated mux with a registered output stage.
// Define RR_ARB_MUX_LOCK_EN to hold the grant on one port until its in_last beat.
module rr_arb_mux
    import rr_arb_pkg::*;
#(
    parameter  int PORT = 4,
    parameter  int DATA = 32,
    localparam int IDX  = $clog2(PORT)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [PORT-1:0]      in_valid,
    input  logic [PORT*DATA-1:0] in_data,
`ifdef RR_ARB_MUX_LOCK_EN
    input  logic [PORT-1:0]      in_last,
`endif
    output logic [PORT-1:0]      in_ready,
    output logic                 out_valid,
    output logic [DATA-1:0]      out_data,
    output logic [IDX-1:0]       out_src,
    input  logic                 out_ready
);

    logic [IDX-1:0]        ptr_q, ptr_d;
    logic [PORT-1:0]       req;
    rr_pick_t              pick;
    logic [IDX-1:0]        win;
    logic [RR_MAX_IDX-1:0] nxt;
    logic                  can_load;
    logic                  accept;
    logic [DATA-1:0]       sel_data;
    logic [IDX+DATA-1:0]   slice_q;
    logic                  unused_idx;

`ifdef RR_ARB_MUX_LOCK_EN
    logic           lock_q;
    logic [IDX-1:0] lock_idx_q;

    // While locked only the owning port may compete; rotation is irrelevant.
    assign req = lock_q ? (in_valid & (PORT'(1) << lock_idx_q)) : in_valid;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lock_q     <= 1'b0;
            lock_idx_q <= '0;
        end else if (accept) begin
            lock_q     <= !in_last[win];
            lock_idx_q <= win;
        end
    end
`else
    assign req = in_valid;
`endif

    assign pick       = rr_pick(RR_MAX_PORT'(req), RR_MAX_IDX'(ptr_q), PORT);
    assign win        = pick.idx[IDX-1:0];
    assign nxt        = rr_next(RR_MAX_IDX'(win), PORT);
    assign ptr_d      = nxt[IDX-1:0];
    assign unused_idx = ^{pick.idx, nxt};

    always_comb begin
        in_ready = '0;
        if (!reset && pick.found && can_load)
            in_ready[win] = 1'b1;
    end

    assign accept   = |in_ready;
    assign sel_data = in_data[win*DATA +: DATA];

    // Under lock the same port keeps winning, so ptr_d stays next-after-owner.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            ptr_q <= '0;
        else if (accept)
            ptr_q <= ptr_d;
    end

    rr_out_slice #(
        .W (IDX + DATA)
    ) u_slice (
        .clk        (clk),
        .reset      (reset),
        .load_i     (accept),
        .data_i     ({win, sel_data}),
        .ready_i    (out_ready),
        .can_load_o (can_load),
        .valid_o    (out_valid),
        .data_o     (slice_q)
    );

    assign out_src  = slice_q[IDX+DATA-1:DATA];
    assign out_data = slice_q[DATA-1:0];

endmodule

// File: tb/tb_rr_arb_mux.sv
// Bench for rr_arb_mux: directed scenarios plus random traffic against a
// queue-free behavioural model (modulo scan from a priority pointer).
module tb_rr_arb_mux;

    localparam int P = 4;
    localparam int D = 32;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic [P-1:0]   in_valid, in_ready, in_last;
    logic [P*D-1:0] in_data;
    logic           out_valid, out_ready;
    logic [D-1:0]   out_data;
    logic [1:0]     out_src;

    logic [2:0]     v3, r3, last3;
    logic [3*D-1:0] d3;
    logic           ov3, ordy3;
    logic [D-1:0]   od3;
    logic [1:0]     os3;

    rr_arb_mux #(.PORT(P), .DATA(D)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_data   (in_data),
`ifdef RR_ARB_MUX_LOCK_EN
        .in_last   (in_last),
`endif
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_src   (out_src),
        .out_ready (out_ready)
    );

    rr_arb_mux #(.PORT(3), .DATA(D)) dut3 (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (v3),
        .in_data   (d3),
`ifdef RR_ARB_MUX_LOCK_EN
        .in_last   (last3),
`endif
        .in_ready  (r3),
        .out_valid (ov3),
        .out_data  (od3),
        .out_src   (os3),
        .out_ready (ordy3)
    );

    int errors = 0;
    int checks = 0;

    // Reference state
    int         m_ptr;
    bit         m_ov;
    logic [D-1:0] m_od;
    int         m_os;
    bit         m_lock;
    int         m_lidx;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    function automatic int m_winner();
        int i;
        for (int k = 0; k < P; k++) begin
            i = (m_ptr + k) % P;
`ifdef RR_ARB_MUX_LOCK_EN
            if (m_lock && i != m_lidx) continue;
`endif
            if (in_valid[i]) return i;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_ptr = 0; m_ov = 0; m_od = '0; m_os = 0; m_lock = 0; m_lidx = 0;
    endtask

    // Inputs must already be driven; checks in_ready, clocks once, checks outputs.
    task automatic step(output int acc);
        int w;
        bit can;
        logic [P-1:0] exp_rdy;
        #1;
        w = m_winner();
        can = !m_ov || out_ready;
        exp_rdy = '0;
        if (w >= 0 && can) exp_rdy[w] = 1'b1;
        chk("in_ready", 64'(in_ready), 64'(exp_rdy));
        @(posedge clk);
        acc = -1;
        if (w >= 0 && can) begin
            acc  = w;
            m_od = in_data[w*D +: D];
            m_os = w;
            m_ov = 1;
            m_ptr = (w + 1) % P;
            m_lock = !in_last[w];
            m_lidx = w;
        end else if (m_ov && out_ready) begin
            m_ov = 0;
        end
        #1;
        chk("out_valid", 64'(out_valid), 64'(m_ov));
        chk("out_data", 64'(out_data), 64'(m_od));
        chk("out_src", 64'(out_src), 64'(m_os));
    endtask

    task automatic do_reset();
        logic [P-1:0] save;
        save = in_valid;
        reset = 1'b1;
        in_valid = '1;
        #1;
        chk("rst_in_ready", 64'(in_ready), 64'(0));
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_out_data", 64'(out_data), 64'(0));
        chk("rst_out_src", 64'(out_src), 64'(0));
        @(posedge clk);
        #1;
        in_valid = save;
        reset = 1'b0;
        model_reset();
    endtask

    initial begin
        int acc;
        logic [P-1:0] pend;
        reset = 1'b1;
        in_valid = '0; in_data = '0; in_last = '1; out_ready = 1'b0;
        v3 = '0; d3 = '0; last3 = '1; ordy3 = 1'b0;
        model_reset();
        do_reset();

        // PORT=3: modulo wrap and alternation on 3'b101
        v3 = 3'b101; ordy3 = 1'b1;
        d3 = {32'h32, 32'h31, 32'h30};
        #1 chk("p3_rdy_first", 64'(r3), 64'(3'b001));
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            chk("p3_alt_src", 64'(os3), 64'((k % 2) ? 2 : 0));
        end
        v3 = 3'b110;
        @(posedge clk); #1 chk("p3_src1", 64'(os3), 64'(1));
        v3 = 3'b100;
        @(posedge clk); #1 chk("p3_src2", 64'(os3), 64'(2));
        v3 = 3'b011;
        #1 chk("p3_wrap_rdy", 64'(r3), 64'(3'b001));
        @(posedge clk); #1 chk("p3_wrap_src", 64'(os3), 64'(0));
        chk("p3_wrap_data", 64'(od3), 64'(32'h30));
        v3 = 3'b000;
        @(posedge clk); #1 chk("p3_drain", 64'(ov3), 64'(0));

        // Fairness sweep
        in_last = '1;
        in_valid = 4'b1111; out_ready = 1'b1;
        for (int i = 0; i < P; i++) in_data[i*D +: D] = 32'h100 + i;
        for (int k = 0; k < 5; k++) begin
            step(acc);
            chk("fair_src", 64'(out_src), 64'(k % 4));
        end

        // Backpressure: output holds 0x100 from port 0
        in_valid = 4'b0100; in_data[2*D +: D] = 32'hA5; out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step(acc);
            chk("bp_rdy", 64'(in_ready), 64'(0));
            chk("bp_hold", 64'(out_data), 64'(32'h100));
        end
        out_ready = 1'b1;
        step(acc);
        chk("bp_data", 64'(out_data), 64'(32'hA5));
        chk("bp_src", 64'(out_src), 64'(2));

        // Simultaneous drain and accept, then plain drain
        in_valid = 4'b0001; in_data[0 +: D] = 32'h1234;
        step(acc);
        chk("sim_valid", 64'(out_valid), 64'(1));
        chk("sim_data", 64'(out_data), 64'(32'h1234));
        in_valid = '0;
        step(acc);
        chk("drain_valid", 64'(out_valid), 64'(0));
        chk("drain_hold", 64'(out_data), 64'(32'h1234));

`ifdef RR_ARB_MUX_LOCK_EN
        // Packet lock: port 0 three beats while port 1 waits
        do_reset();
        in_valid = 4'b0011; in_last = 4'b1110; out_ready = 1'b1;
        in_data[0 +: D] = 32'hB0; in_data[D +: D] = 32'hC1;
        step(acc); chk("lock_src0", 64'(out_src), 64'(0));
        in_data[0 +: D] = 32'hB1;
        step(acc); chk("lock_src1", 64'(out_src), 64'(0));
        in_data[0 +: D] = 32'hB2; in_last = 4'b1111;
        step(acc); chk("lock_src2", 64'(out_src), 64'(0));
        in_valid = 4'b0010;
        step(acc); chk("lock_after", 64'(out_src), 64'(1));

        // Reset mid-packet on port 1
        in_valid = 4'b0010; in_last = 4'b1101; out_ready = 1'b0;
        step(acc);
        do_reset();
        chk("rst_mid_valid", 64'(out_valid), 64'(0));
        in_valid = 4'b0100; in_last = 4'b1111; in_data[2*D +: D] = 32'hD2;
        #1 chk("rst_mid_grant", 64'(in_ready), 64'(4'b0100));
        step(acc);
        chk("rst_mid_src", 64'(out_src), 64'(2));
        in_valid = '0; out_ready = 1'b1;
        step(acc);
`endif

        // Random traffic honouring the hold-until-accepted producer rule
        pend = '0;
        in_valid = '0;
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < P; i++) begin
                if (!pend[i] && $urandom_range(0, 2) == 0) begin
                    pend[i] = 1'b1;
                    in_data[i*D +: D] = $urandom;
                    in_last[i] = ($urandom_range(0, 2) != 0);
                end
            end
            in_valid  = pend;
            out_ready = ($urandom_range(0, 3) != 0);
            step(acc);
            if (acc >= 0) pend[acc] = 1'b0;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
